// File: rtl/adder_switch_conditioner.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | adder_switch_conditioner: sync, debounce, clamp and route board switches    |
// | into registered adder operands; emits a one-clock calculate strobe.         |
// | Optional: ADDER_SWITCH_FREEZE_EN holds operands while debounced cal is high. |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module adder_switch_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int CLAMP_MAX       = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] switchs,
  input  logic       switch_mode,
  input  logic       switch_cal,
  output logic [6:0] operand_a,
  output logic [6:0] operand_b,
  output logic       mode_stable,
  output logic       cal_pulse,
  output logic       operand_upd
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [6:0]       CLAMP_V  = 7'(CLAMP_MAX);

  logic [8:0] raw_all;
  logic [8:0] stable_all;

  assign raw_all = {switch_cal, switch_mode, switchs};

  // Channel 0 is the 7-bit switch group, channel 1 is mode, channel 2 is cal.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      localparam int LO = (gi == 0) ? 0 : gi + 6;
      localparam int W  = (gi == 0) ? 7 : 1;

      logic [W-1:0]     s1_q;
      logic [W-1:0]     s2_q;
      logic [W-1:0]     s2_prev_q;
      logic [W-1:0]     stable_q;
      logic [W-1:0]     stable_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q + CNT_W'(1);
        if ((s2_q != s2_prev_q) || (s2_q == stable_q)) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          stable_d = s2_q;
          cnt_d    = '0;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s1_q      <= '0;
          s2_q      <= '0;
          s2_prev_q <= '0;
          stable_q  <= '0;
          cnt_q     <= '0;
        end else begin
          s1_q      <= raw_all[LO +: W];
          s2_q      <= s1_q;
          s2_prev_q <= s2_q;
          stable_q  <= stable_d;
          cnt_q     <= cnt_d;
        end
      end

      assign stable_all[LO +: W] = stable_q;
    end
  endgenerate

  logic [6:0] sw_st;
  logic       mode_st;
  logic       cal_st;
  logic [6:0] sw_clamped;
  logic       freeze;

  assign sw_st      = stable_all[6:0];
  assign mode_st    = stable_all[7];
  assign cal_st     = stable_all[8];
  assign sw_clamped = (sw_st >= CLAMP_V) ? CLAMP_V : sw_st;

`ifdef ADDER_SWITCH_FREEZE_EN
  assign freeze = cal_st;
`else
  assign freeze = 1'b0;
`endif

  logic [6:0] operand_a_q, operand_a_d;
  logic [6:0] operand_b_q, operand_b_d;
  logic       cal_prev_q, cal_prev_d;
  logic       cal_pulse_q, cal_pulse_d;
  logic       operand_upd_q, operand_upd_d;

  always_comb begin
    operand_a_d = operand_a_q;
    operand_b_d = operand_b_q;
    if (!freeze) begin
      if (mode_st) begin
        operand_a_d = sw_clamped;
      end else begin
        operand_b_d = sw_clamped;
      end
    end
    operand_upd_d = (operand_a_d != operand_a_q) || (operand_b_d != operand_b_q);
    cal_pulse_d   = cal_st & ~cal_prev_q;
    cal_prev_d    = cal_st;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      operand_a_q   <= '0;
      operand_b_q   <= '0;
      cal_prev_q    <= 1'b0;
      cal_pulse_q   <= 1'b0;
      operand_upd_q <= 1'b0;
    end else begin
      operand_a_q   <= operand_a_d;
      operand_b_q   <= operand_b_d;
      cal_prev_q    <= cal_prev_d;
      cal_pulse_q   <= cal_pulse_d;
      operand_upd_q <= operand_upd_d;
    end
  end

  assign operand_a   = operand_a_q;
  assign operand_b   = operand_b_q;
  assign mode_stable = mode_st;
  assign cal_pulse   = cal_pulse_q;
  assign operand_upd = operand_upd_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_switch_conditioner.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_adder_switch_conditioner: directed stimulus with a run-length behavioural |
// | model of the switch conditioner. Revision: 1.0                              |
// +-----------------------------------------------------------------------------+
module tb_adder_switch_conditioner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] switchs;
  logic       switch_mode;
  logic       switch_cal;
  logic [6:0] operand_a;
  logic [6:0] operand_b;
  logic       mode_stable;
  logic       cal_pulse;
  logic       operand_upd;

  adder_switch_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (20),
    .CLAMP_MAX      (99)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .switchs    (switchs),
    .switch_mode(switch_mode),
    .switch_cal (switch_cal),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .mode_stable(mode_stable),
    .cal_pulse  (cal_pulse),
    .operand_upd(operand_upd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a channel's debounced level becomes a sampled value
  // once that value has been seen for D+1 consecutive samples, two edges after
  // the last of those samples reached the first synchroniser stage.
  logic [6:0] p0v[3], p1v[3], st[3];
  int         p0l[3], p1l[3];
  logic [6:0] m_a, m_b;
  logic       m_pulse, m_upd, m_cal_prev;
  bit         model_valid = 0;

  function automatic logic [6:0] clampf(input logic [6:0] v);
    return (v >= 7'd99) ? 7'd99 : v;
  endfunction

  always @(posedge clk) begin
    logic [6:0] raw[3];
    logic [6:0] na, nb;
    bit frz;
    raw[0] = switchs;
    raw[1] = {6'd0, switch_mode};
    raw[2] = {6'd0, switch_cal};
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        p0v[c] = '0; p1v[c] = '0; p0l[c] = 1; p1l[c] = 1; st[c] = '0;
      end
      m_a = '0; m_b = '0; m_pulse = 0; m_upd = 0; m_cal_prev = 0;
      model_valid = 1;
    end else begin
      na = m_a;
      nb = m_b;
      frz = 0;
`ifdef ADDER_SWITCH_FREEZE_EN
      frz = st[2][0];
`endif
      if (!frz) begin
        if (st[1][0]) na = clampf(st[0]);
        else          nb = clampf(st[0]);
      end
      m_upd      = (na != m_a) || (nb != m_b);
      m_a        = na;
      m_b        = nb;
      m_pulse    = st[2][0] && !m_cal_prev;
      m_cal_prev = st[2][0];
      for (int c = 0; c < 3; c++) begin
        if (p1l[c] >= D + 1) st[c] = p1v[c];
        p1v[c] = p0v[c];
        p1l[c] = p0l[c];
        p0l[c] = (raw[c] == p0v[c]) ? ((p0l[c] < 1000) ? p0l[c] + 1 : p0l[c]) : 1;
        p0v[c] = raw[c];
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("model_operand_a",   int'(operand_a),   int'(m_a));
      check("model_operand_b",   int'(operand_b),   int'(m_b));
      check("model_mode_stable", int'(mode_stable), int'(st[1][0]));
      check("model_cal_pulse",   int'(cal_pulse),   int'(m_pulse));
      check("model_operand_upd", int'(operand_upd), int'(m_upd));
      if (cal_pulse) pulse_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_a1, exp_u1;
`ifdef ADDER_SWITCH_FREEZE_EN
    exp_a1 = 0;  exp_u1 = 0;
`else
    exp_a1 = 99; exp_u1 = 1;
`endif
    // 1: reset with all switches high, then release
    rst_n = 0; switchs = 7'h7F; switch_mode = 1; switch_cal = 1;
    step(3);
    check("rst_operand_a", int'(operand_a), 0);
    check("rst_operand_b", int'(operand_b), 0);
    check("rst_mode_stable", int'(mode_stable), 0);
    check("rst_cal_pulse", int'(cal_pulse), 0);
    check("rst_operand_upd", int'(operand_upd), 0);
    rst_n = 1;
    step(7);
    check("t1_a_before", int'(operand_a), 0);
    check("t1_pulse_before", int'(cal_pulse), 0);
    step(1);
    check("t1_a_clamped", int'(operand_a), exp_a1);
    check("t1_upd", int'(operand_upd), exp_u1);
    check("t1_cal_pulse", int'(cal_pulse), 1);
    check("t1_b_zero", int'(operand_b), 0);
    step(1);
    check("t1_pulse_one_cycle", int'(cal_pulse), 0);
    switch_cal = 0;
    step(10);

    // 2: operand A then operand B
    switchs = 7'd42;
    step(7);
    check("t2_a_before", int'(operand_a), 99);
    step(1);
    check("t2_a_42", int'(operand_a), 42);
    check("t2_upd", int'(operand_upd), 1);
    step(1);
    check("t2_upd_drop", int'(operand_upd), 0);
    switch_mode = 0; switchs = 7'd17;
    step(8);
    check("t2_b_17", int'(operand_b), 17);
    check("t2_a_hold", int'(operand_a), 42);
    step(2);

    // 3: short bounces are rejected
    switch_mode = 1; switchs = 7'd42;
    step(10);
    switchs = 7'd55; step(3);
    switchs = 7'd42; step(3);
    switchs = 7'd55; step(3);
    switchs = 7'd42; step(10);
    check("t3_a_glitch", int'(operand_a), 42);
    check("t3_b_hold", int'(operand_b), 17);
    switchs = 7'd55;
    step(8);
    check("t3_a_55", int'(operand_a), 55);

    // 4: clamp boundaries on operand B
    switch_mode = 0; switchs = 7'd100;
    step(8);
    check("t4_b_100", int'(operand_b), 99);
    switchs = 7'd99;
    step(12);
    check("t4_b_99", int'(operand_b), 99);
    switchs = 7'd98;
    step(8);
    check("t4_b_98", int'(operand_b), 98);

    // 5: calculate strobe
    pulse_cnt = 0;
    switch_cal = 1;
    step(7);
    check("t5_pulse_early", int'(cal_pulse), 0);
    step(1);
    check("t5_pulse", int'(cal_pulse), 1);
    step(12);
    switch_cal = 0; step(20);
    switch_cal = 1; step(20);
    check("t5_pulse_count", pulse_cnt, 2);
    switch_cal = 0; step(20);
    pulse_cnt = 0;
    switch_cal = 1; step(2);
    switch_cal = 0; step(15);
    check("t5_glitch_count", pulse_cnt, 0);

`ifdef ADDER_SWITCH_FREEZE_EN
    // 6: operands frozen while cal is high
    switch_mode = 1; switchs = 7'd42; step(10);
    switch_cal = 1; step(10);
    switchs = 7'd60; step(10);
    check("t6_a_frozen", int'(operand_a), 42);
    switch_cal = 0;
    step(7);
    check("t6_a_still", int'(operand_a), 42);
    step(1);
    check("t6_a_resume", int'(operand_a), 60);
`endif

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
